// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// master drives requests and consumes results; slave is the divider itself.
interface seq_divider_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, STEP quotient bits per cycle.
// state | meaning
// IDLE  | waiting for a request, in_ready high unless flushed
// CALC  | one restoring iteration per cycle until the down-counter hits zero
// FIX   | sign correction of quotient/remainder and result select
// DONE  | result and tag held until out_ready
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  seq_divider_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [CW-1:0]    cnt;
  logic             rem_sel;
  logic             sign_q;
  logic             sign_r;
  logic             out_valid_q;

  logic             is_signed;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign is_signed = !bus.op[0];
  assign a_abs     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign b_zero    = (bus.b == '0);
  assign ovf       = is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);

  // quo_q starts as the dividend and fills with quotient bits from the bottom
  logic [WIDTH-1:0] rem_v;
  logic [WIDTH-1:0] quo_v;
  logic [WIDTH:0]   shf;
  logic [WIDTH-1:0] dif;

  always_comb begin
    rem_v = rem_q;
    quo_v = quo_q;
    shf   = '0;
    dif   = '0;
    for (int i = 0; i < STEP; i++) begin
      shf = {rem_v, quo_v[WIDTH-1]};
      dif = shf[WIDTH-1:0] - dvs_q;
      if (shf >= {1'b0, dvs_q}) begin
        rem_v = dif;
        quo_v = {quo_v[WIDTH-2:0], 1'b1};
      end else begin
        rem_v = shf[WIDTH-1:0];
        quo_v = {quo_v[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      tag_q       <= '0;
      out_tag_q   <= '0;
      cnt         <= '0;
      rem_sel     <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem_sel <= bus.op[1];
            tag_q   <= bus.in_tag;
            sign_q  <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r  <= is_signed && bus.a[WIDTH-1];
            dvs_q   <= b_abs;
            quo_q   <= a_abs;
            rem_q   <= '0;
            cnt     <= CW'(N);
            if (b_zero) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= bus.op[1] ? bus.a : '1;
              out_tag_q   <= bus.in_tag;
            end else if (ovf) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= bus.op[1] ? '0 : bus.a;
              out_tag_q   <= bus.in_tag;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            rem_q <= rem_v;
            quo_q <= quo_v;
            cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          result_q    <= rem_sel ? (sign_r ? -rem_q : rem_q)
                                 : (sign_q ? -quo_q : quo_q);
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;
endmodule
